// File: rtl/duty_ramp_pkg.sv
// Shared types and default constants for the duty_ramp slew limiter.
// Optional soft-start is enabled with `define DUTY_RAMP_SOFT_START_EN.
package duty_ramp_pkg;

  localparam int DUTY_W    = 11;
  localparam int RAMP_STEP = 16;
  localparam int PER_BITS  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/duty_ramp_if.sv
// Bundle between the duty request source (master) and the duty_ramp limiter (slave).
interface duty_ramp_if
  import duty_ramp_pkg::*;
#(
  parameter int WIDTH = DUTY_W
);

  // target/en are plain levels sampled on every clock (no valid/ready);
  // duty/ramping/state are registered levels; done is a one-clock pulse.
  logic [WIDTH-1:0] target;
  logic             en;
  logic [WIDTH-1:0] duty;
  logic             ramping;
  logic             done;
  ramp_state_t      state;

  modport master (
    output target, en,
    input  duty, ramping, done, state
  );

  modport slave (
    input  target, en,
    output duty, ramping, done, state
  );

endinterface

// File: rtl/duty_ramp_period_tick.sv
// Free-running prescaler; tick is high for one clock every 2^PER_BITS clocks.
module period_tick #(
  parameter int PER_BITS = 11
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [PER_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_q + PER_BITS'(1);
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/duty_ramp.sv
// Slew-rate limiter feeding PWM11.duty: moves duty toward target by STEP once per PWM period.
// Optional macro DUTY_RAMP_SOFT_START_EN: first ramp after reset steps by 1 below 2^(WIDTH-4).
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int WIDTH    = duty_ramp_pkg::DUTY_W,
  parameter int STEP     = duty_ramp_pkg::RAMP_STEP,
  parameter int PER_BITS = duty_ramp_pkg::PER_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  duty_ramp_if.slave  bus
);

  localparam logic signed [WIDTH:0] STEP_S = (WIDTH+1)'(STEP);

  ramp_state_t             state_q, state_d;
  logic        [WIDTH-1:0] duty_q, duty_d;
  logic                    done_q, done_d;
  logic                    ramping_q;
  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH:0]   up_step;
  logic                    tick;

  period_tick #(.PER_BITS(PER_BITS)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

`ifdef DUTY_RAMP_SOFT_START_EN
  localparam logic [WIDTH-1:0] SOFT_LIMIT = WIDTH'(1) << (WIDTH-4);
  logic soft_done_q, soft_done_d;

  // Once duty has reached the soft limit, the fine-step region never applies again.
  always_comb begin
    soft_done_d = soft_done_q | (duty_q >= SOFT_LIMIT);
    up_step     = (!soft_done_q && (duty_q < SOFT_LIMIT)) ? (WIDTH+1)'(1) : STEP_S;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) soft_done_q <= 1'b0;
    else        soft_done_q <= soft_done_d;
  end
`else
  assign up_step = STEP_S;
`endif

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    diff    = '0;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (bus.target > duty_q)      state_d = UP;
          else if (bus.target < duty_q) state_d = DN;
        end
        UP: begin
          if (tick) begin
            diff = $signed({1'b0, bus.target}) - $signed({1'b0, duty_q});
            if (diff[WIDTH]) begin
              state_d = DN;
            end else if (diff > up_step) begin
              duty_d = duty_q + up_step[WIDTH-1:0];
            end else begin
              // Final (possibly partial) step lands exactly on target, never past it.
              duty_d  = bus.target;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        DN: begin
          if (tick) begin
            diff = $signed({1'b0, duty_q}) - $signed({1'b0, bus.target});
            if (diff[WIDTH]) begin
              state_d = UP;
            end else if (diff > STEP_S) begin
              duty_d = duty_q - STEP_S[WIDTH-1:0];
            end else begin
              duty_d  = bus.target;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      done_q    <= 1'b0;
      ramping_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      done_q    <= done_d;
      ramping_q <= (state_d != IDLE);
    end
  end

  assign bus.duty    = duty_q;
  assign bus.ramping = ramping_q;
  assign bus.done    = done_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp with PER_BITS=4 (tick every 16 clocks), STEP=16, WIDTH=11.
module tb_duty_ramp;
  import duty_ramp_pkg::*;

`ifdef DUTY_RAMP_SOFT_START_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   n_ticks;
  bit   soft_active;
  logic [10:0] exp_duty;

  duty_ramp_if #(.WIDTH(11)) bus ();

  duty_ramp #(.WIDTH(11), .STEP(16), .PER_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  // Advance to #1 after the next edge on which duty may update.
  task automatic to_tick();
    clk_n(16 - (cyc % 16));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_duty",    32'(bus.duty),    32'h0);
    chk("rst_ramping", 32'(bus.ramping), 32'h0);
    chk("rst_done",    32'(bus.done),    32'h0);
    chk("rst_state",   32'(bus.state),   32'(IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    cyc         = 0;
    soft_active = SOFT_EN;
  endtask

  task automatic up_ramp(input logic [10:0] stop, input logic [10:0] tgt, input string tag,
                         output int n);
    int st;
    n = 0;
    while (exp_duty != stop) begin
      st = (soft_active && exp_duty < 11'd128) ? 1 : 16;
      if (int'(stop) - int'(exp_duty) > st) exp_duty = exp_duty + 11'(st);
      else                                  exp_duty = stop;
      if (exp_duty >= 11'd128) soft_active = 1'b0;
      to_tick();
      n++;
      chk({tag, "_duty"},    32'(bus.duty),    32'(exp_duty));
      chk({tag, "_done"},    32'(bus.done),    32'(exp_duty == tgt));
      chk({tag, "_ramping"}, 32'(bus.ramping), 32'(exp_duty != tgt));
    end
  endtask

  task automatic dn_ramp(input logic [10:0] stop, input logic [10:0] tgt, input string tag,
                         output int n);
    n = 0;
    while (exp_duty != stop) begin
      if (int'(exp_duty) - int'(stop) > 16) exp_duty = exp_duty - 11'd16;
      else                                  exp_duty = stop;
      to_tick();
      n++;
      chk({tag, "_duty"}, 32'(bus.duty), 32'(exp_duty));
      chk({tag, "_done"}, 32'(bus.done), 32'(exp_duty == tgt));
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    cyc         = 0;
    soft_active = 1'b0;
    rst_n       = 1'b1;
    bus.target  = '0;
    bus.en      = 1'b0;
    #2;

    // 1: ramp 0 -> 0x400
    bus.target = 11'h400;
    bus.en     = 1'b1;
    do_reset();
    exp_duty = '0;
    clk_n(1);
    chk("t1_entry_duty",    32'(bus.duty),    32'h0);
    chk("t1_entry_ramping", 32'(bus.ramping), 32'h1);
    chk("t1_entry_state",   32'(bus.state),   32'(UP));
    up_ramp(11'h400, 11'h400, "t1", n_ticks);
    chk("t1_ticks", 32'(n_ticks), SOFT_EN ? 32'd184 : 32'd64);
    clk_n(1);
    chk("t1_done_drop", 32'(bus.done), 32'h0);

    // 2: ramp 0x400 -> 0x010
    bus.target = 11'h010;
    clk_n(1);
    chk("t2_entry_state", 32'(bus.state), 32'(DN));
    chk("t2_entry_duty",  32'(bus.duty),  32'h400);
    dn_ramp(11'h010, 11'h010, "t2", n_ticks);
    chk("t2_ticks", 32'(n_ticks), 32'd63);

    // equal target stays idle
    clk_n(1);
    chk("eq_done", 32'(bus.done), 32'h0);
    to_tick();
    chk("eq_ramping", 32'(bus.ramping), 32'h0);
    chk("eq_duty",    32'(bus.duty),    32'h010);

    // 3: up to 0x3F0, then clamp onto 0x405
    bus.target = 11'h3F0;
    clk_n(1);
    up_ramp(11'h3F0, 11'h3F0, "t3a", n_ticks);
    chk("t3a_ticks", 32'(n_ticks), 32'd62);
    bus.target = 11'h405;
    clk_n(1);
    to_tick();
    chk("t3_step_duty", 32'(bus.duty), 32'h400);
    chk("t3_step_done", 32'(bus.done), 32'h0);
    to_tick();
    chk("t3_clamp_duty",    32'(bus.duty),    32'h405);
    chk("t3_clamp_done",    32'(bus.done),    32'h1);
    chk("t3_clamp_ramping", 32'(bus.ramping), 32'h0);

    // 6: reset mid-ramp, then ramp up again
    bus.target = 11'h000;
    clk_n(1);
    to_tick();
    chk("t6_pre1", 32'(bus.duty), 32'h3F5);
    to_tick();
    chk("t6_pre2", 32'(bus.duty), 32'h3E5);
    clk_n(5);
    #3;
    bus.target = 11'h400;
    do_reset();
    exp_duty = '0;
    clk_n(1);
    up_ramp(11'h200, 11'h400, "t6", n_ticks);
    chk("t6_ticks", 32'(n_ticks), SOFT_EN ? 32'd152 : 32'd32);

    // 4: reversal at 0x200
    bus.target = 11'h000;
    to_tick();
    chk("t4_rev_duty",    32'(bus.duty),    32'h200);
    chk("t4_rev_state",   32'(bus.state),   32'(DN));
    chk("t4_rev_ramping", 32'(bus.ramping), 32'h1);
    dn_ramp(11'h100, 11'h000, "t4", n_ticks);
    chk("t4_ticks", 32'(n_ticks), 32'd16);

    // 5: freeze with en=0
    bus.en = 1'b0;
    clk_n(50);
    chk("t5_hold50_duty", 32'(bus.duty), 32'h100);
    chk("t5_hold50_done", 32'(bus.done), 32'h0);
    clk_n(50);
    chk("t5_hold100_duty",  32'(bus.duty),  32'h100);
    chk("t5_hold100_done",  32'(bus.done),  32'h0);
    chk("t5_hold100_state", 32'(bus.state), 32'(DN));
    bus.en = 1'b1;
    to_tick();
    chk("t5_resume1", 32'(bus.duty), 32'h0F0);
    to_tick();
    chk("t5_resume2", 32'(bus.duty), 32'h0E0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
